// File: rtl/scc_wave_ram_arbiter.sv
// scc_wave_ram_arbiter
// Arbitrates the single-port SCC wave RAM (5 channels x 32 bytes) between the
// CPU register port and the tone-generator sample fetcher. The tone generator
// has fixed priority; a saturating starvation counter bounds how long a
// pending CPU access can lose. CPU strobes land in a one-entry pending buffer
// (latest strobe wins). Read data returns through a two-stage tag pipe that
// steers ram_q to the CPU or tone-generator result register.
`timescale 1ns/1ps

module scc_wave_ram_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int RAM_AW       = 8
) (
    input  logic              nreset,
    input  logic              clk,
    // CPU register port
    input  logic [2:0]        cpu_id,
    input  logic [4:0]        cpu_a,
    input  logic [7:0]        cpu_d,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic [7:0]        cpu_q,
    output logic              cpu_q_en,
    output logic              cpu_busy,
    // tone-generator fetch port
    input  logic              tg_req,
    input  logic [2:0]        tg_id,
    input  logic [4:0]        tg_a,
    output logic              tg_ack,
    output logic [7:0]        tg_q,
    output logic              tg_q_en,
    // wave RAM macro
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_d,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [7:0]        ram_q
);

    // Wide enough to hold 0..STARVE_LIMIT, never narrower than one bit.
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Grant decision for the current cycle.
    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_TG   = 2'd1;
    localparam logic [1:0] GRANT_CPU  = 2'd2;

    // Channel ids 0..4 are real; 5..7 never touch the RAM.
    localparam logic [2:0] LAST_ID = 3'd4;

    // Data returned for reads of a nonexistent channel.
    localparam logic [7:0] CPU_BAD_ID_Q = 8'hFF;
    localparam logic [7:0] TG_BAD_ID_Q  = 8'h00;

    // ------------------------------------------------------------------
    // Pending CPU request buffer
    // ------------------------------------------------------------------
    logic          pend_valid;
    logic [2:0]    pend_id;
    logic [4:0]    pend_a;
    logic [7:0]    pend_d;
    logic          pend_wr;
    logic [SW-1:0] starve_cnt;

    // ------------------------------------------------------------------
    // Grant and command selection
    // ------------------------------------------------------------------
    logic [1:0] grant;
    logic [2:0] sel_id;
    logic [4:0] sel_a;
    logic       sel_bad_id;
    logic       cmd_read;   // grant wants data back (real or substituted)
    logic       issue_re;   // grant actually reads the RAM
    logic       issue_we;   // grant actually writes the RAM

    // ------------------------------------------------------------------
    // Return tag pipe: stage 1 aligns with ram_re, stage 2 with ram_q
    // ------------------------------------------------------------------
    logic tag1_valid, tag1_cpu, tag1_bad;
    logic tag2_valid, tag2_cpu, tag2_bad;

    // Pick the winner: tone generator unless the CPU has waited out its limit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = GRANT_NONE;
        if (tg_req && !(pend_valid && (starve_cnt == STARVE_MAX))) begin
            grant = GRANT_TG;
        end else if (pend_valid) begin
            grant = GRANT_CPU;
        end
    end

    // Address, direction and id validity of the winning request.
    always_comb begin
        sel_id   = pend_id;
        sel_a    = pend_a;
        cmd_read = 1'b0;
        issue_we = 1'b0;
        if (grant == GRANT_TG) begin
            sel_id   = tg_id;
            sel_a    = tg_a;
            cmd_read = 1'b1;
        end else if (grant == GRANT_CPU) begin
            cmd_read = !pend_wr;
            issue_we = pend_wr && (pend_id <= LAST_ID);
        end
        sel_bad_id = (sel_id > LAST_ID);
        issue_re   = cmd_read && !sel_bad_id;
    end

    assign tg_ack   = (grant == GRANT_TG);
    assign cpu_busy = pend_valid;

    // Capture CPU strobes; a strobe always wins over retiring the old entry.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in the design samples the same pre-edge values.
            pend_valid <= 1'b0;
            pend_id    <= '0;
            pend_a     <= '0;
            pend_d     <= '0;
            pend_wr    <= 1'b0;
        end else if (cpu_we || cpu_oe) begin
            pend_valid <= 1'b1;
            pend_id    <= cpu_id;
            pend_a     <= cpu_a;
            pend_d     <= cpu_d;
            pend_wr    <= cpu_we;   // write wins when both strobes are high
        end else if (grant == GRANT_CPU) begin
            pend_valid <= 1'b0;
        end
    end

    // Count cycles a pending CPU request loses; an overwrite keeps the count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            starve_cnt <= '0;
        end else if ((grant == GRANT_CPU) || !pend_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Register the RAM command; address and write data hold between commands.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ram_addr <= '0;
            ram_d    <= '0;
            ram_re   <= 1'b0;
            ram_we   <= 1'b0;
        end else begin
            ram_re <= issue_re;
            ram_we <= issue_we;
            if (issue_re || issue_we) begin
                ram_addr <= RAM_AW'({sel_id, sel_a});
            end
            if (issue_we) begin
                ram_d <= pend_d;
            end
        end
    end

    // Carry ownership of each read (including bad-id reads) down the tag pipe.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tag1_valid <= 1'b0;
            tag1_cpu   <= 1'b0;
            tag1_bad   <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_cpu   <= 1'b0;
            tag2_bad   <= 1'b0;
        end else begin
            tag1_valid <= cmd_read;
            tag1_cpu   <= (grant == GRANT_CPU);
            tag1_bad   <= sel_bad_id;
            tag2_valid <= tag1_valid;
            tag2_cpu   <= tag1_cpu;
            tag2_bad   <= tag1_bad;
        end
    end

    // Land returned data in the owner's result register with a one-cycle pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cpu_q    <= '0;
            cpu_q_en <= 1'b0;
            tg_q     <= '0;
            tg_q_en  <= 1'b0;
        end else begin
            cpu_q_en <= tag2_valid && tag2_cpu;
            tg_q_en  <= tag2_valid && !tag2_cpu;
            if (tag2_valid && tag2_cpu) begin
                cpu_q <= tag2_bad ? CPU_BAD_ID_Q : ram_q;
            end
            if (tag2_valid && !tag2_cpu) begin
                tg_q <= tag2_bad ? TG_BAD_ID_Q : ram_q;
            end
        end
    end

    // The RAM port carries at most one operation per cycle.
    always @(posedge clk) begin
        if (nreset) begin
            assert (!(ram_re && ram_we))
                else $error("ram_re and ram_we asserted together");
        end
    end

endmodule

// File: tb/tb_scc_wave_ram_arbiter.sv
// tb_scc_wave_ram_arbiter
// Drives directed scenarios followed by random CPU/tone-generator traffic and
// compares every output, every cycle, against a transaction-level model that
// schedules expected RAM commands and read returns by their fixed latencies.
`timescale 1ns/1ps

module tb_scc_wave_ram_arbiter;

    localparam int LIMIT = 3;

    logic       nreset;
    logic       clk;
    logic [2:0] cpu_id;
    logic [4:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_oe, cpu_we;
    logic [7:0] cpu_q;
    logic       cpu_q_en, cpu_busy;
    logic       tg_req;
    logic [2:0] tg_id;
    logic [4:0] tg_a;
    logic       tg_ack;
    logic [7:0] tg_q;
    logic       tg_q_en;
    logic [7:0] ram_addr, ram_d;
    logic       ram_re, ram_we;
    logic [7:0] ram_q;

    scc_wave_ram_arbiter #(.STARVE_LIMIT(LIMIT), .RAM_AW(8)) dut (
        .nreset(nreset), .clk(clk),
        .cpu_id(cpu_id), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_oe(cpu_oe), .cpu_we(cpu_we),
        .cpu_q(cpu_q), .cpu_q_en(cpu_q_en), .cpu_busy(cpu_busy),
        .tg_req(tg_req), .tg_id(tg_id), .tg_a(tg_a),
        .tg_ack(tg_ack), .tg_q(tg_q), .tg_q_en(tg_q_en),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_re(ram_re), .ram_we(ram_we),
        .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wave RAM macro: synchronous write, one-cycle read latency.
    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_d;
        if (ram_re) ram_q <= ram_mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected-event timeline, indexed by cycle modulo 8.
    bit         s_re [8], s_we [8], s_cq_en [8], s_tq_en [8];
    logic [7:0] s_addr [8], s_d [8], s_cq [8], s_tq [8];
    logic [7:0] m_mem [256];
    // Outstanding CPU request and how many cycles it has lost so far.
    bit         m_pv, m_pwr;
    logic [2:0] m_pid;
    logic [4:0] m_pa;
    logic [7:0] m_pd;
    int         m_lost;
    // Values the held outputs should currently show.
    logic [7:0] m_last_d, m_last_cq, m_last_tq;
    // Observations exposed to the directed sequences.
    bit         obs_ack, obs_we, m_tg_won;

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            s_re[i] = 0; s_we[i] = 0; s_cq_en[i] = 0; s_tq_en[i] = 0;
            s_addr[i] = '0; s_d[i] = '0; s_cq[i] = '0; s_tq[i] = '0;
        end
        m_pv = 0; m_pwr = 0; m_pid = '0; m_pa = '0; m_pd = '0; m_lost = 0;
        m_last_d = '0; m_last_cq = '0; m_last_tq = '0;
    endtask

    // One clock cycle: drive inputs, predict, compare at the falling edge.
    task automatic step(input bit rst, input bit we, input bit oe,
                        input logic [2:0] id, input logic [4:0] a, input logic [7:0] d,
                        input bit treq, input logic [2:0] tid, input logic [4:0] ta);
        int  slot;
        bit  cpu_win, tg_win;
        int  g1, g3;
        @(posedge clk); #1;
        nreset = !rst;
        cpu_we = we; cpu_oe = oe; cpu_id = id; cpu_a = a; cpu_d = d;
        tg_req = treq; tg_id = tid; tg_a = ta;
        slot = cyc % 8; g1 = (cyc + 1) % 8; g3 = (cyc + 3) % 8;
        cpu_win = 0; tg_win = 0;
        if (rst) begin
            clear_model();
        end else begin
            // Tone generator first, unless the CPU has already lost LIMIT times.
            cpu_win = m_pv && (!treq || m_lost >= LIMIT);
            tg_win  = treq && !cpu_win;
            if (tg_win) begin
                if (tid < 5) begin
                    s_re[g1] = 1; s_addr[g1] = tid * 32 + ta;
                    s_tq[g3] = m_mem[tid * 32 + ta];
                end else begin
                    s_tq[g3] = 8'h00;
                end
                s_tq_en[g3] = 1;
            end else if (cpu_win) begin
                if (m_pwr) begin
                    if (m_pid < 5) begin
                        s_we[g1] = 1; s_addr[g1] = m_pid * 32 + m_pa; s_d[g1] = m_pd;
                        m_mem[m_pid * 32 + m_pa] = m_pd;
                    end
                end else begin
                    if (m_pid < 5) begin
                        s_re[g1] = 1; s_addr[g1] = m_pid * 32 + m_pa;
                        s_cq[g3] = m_mem[m_pid * 32 + m_pa];
                    end else begin
                        s_cq[g3] = 8'hFF;
                    end
                    s_cq_en[g3] = 1;
                end
            end
        end
        if (s_we[slot])    m_last_d  = s_d[slot];
        if (s_cq_en[slot]) m_last_cq = s_cq[slot];
        if (s_tq_en[slot]) m_last_tq = s_tq[slot];

        @(negedge clk);
        check("cpu_busy", cpu_busy, m_pv);
        check("tg_ack",   tg_ack,   tg_win);
        check("ram_re",   ram_re,   s_re[slot]);
        check("ram_we",   ram_we,   s_we[slot]);
        if (s_re[slot] || s_we[slot]) check("ram_addr", ram_addr, s_addr[slot]);
        if (rst) check("ram_addr_rst", ram_addr, 8'h00);
        check("ram_d",    ram_d,    m_last_d);
        check("cpu_q_en", cpu_q_en, s_cq_en[slot]);
        check("cpu_q",    cpu_q,    m_last_cq);
        check("tg_q_en",  tg_q_en,  s_tq_en[slot]);
        check("tg_q",     tg_q,     m_last_tq);
        obs_ack = tg_ack; obs_we = ram_we; m_tg_won = tg_win;

        // Advance the model's request state to the next cycle.
        if (!rst) begin
            if (cpu_win || !m_pv) m_lost = 0;
            else if (m_lost < LIMIT) m_lost++;
            if (we || oe) begin
                m_pv = 1; m_pwr = we; m_pid = id; m_pa = a; m_pd = d;
            end else if (cpu_win) begin
                m_pv = 0;
            end
        end
        s_re[slot] = 0; s_we[slot] = 0; s_cq_en[slot] = 0; s_tq_en[slot] = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 5'd0, 8'h00, 0, 3'd0, 5'd0);
    endtask

    // Random tone-generator request held until acknowledged.
    bit         tg_hold;
    logic [2:0] tg_hid;
    logic [4:0] tg_ha;

    initial begin
        int ack_seen [5];
        int we_count;
        nreset = 1'b0;
        cpu_we = 0; cpu_oe = 0; cpu_id = '0; cpu_a = '0; cpu_d = '0;
        tg_req = 0; tg_id = '0; tg_a = '0;
        ram_q = '0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram_mem[i] = v;
            m_mem[i]   = v;
        end
        clear_model();

        // Reset state.
        step(1, 0, 0, 3'd0, 5'd0, 8'h00, 0, 3'd0, 5'd0);
        step(1, 0, 0, 3'd0, 5'd0, 8'h00, 0, 3'd0, 5'd0);
        idle(2);

        // Uncontended write id2 a5 -> RAM 0x45.
        step(0, 1, 0, 3'd2, 5'd5, 8'h5A, 0, 3'd0, 5'd0);
        idle(4);

        // Uncontended read of the same byte.
        step(0, 0, 1, 3'd2, 5'd5, 8'h00, 0, 3'd0, 5'd0);
        idle(5);

        // Starvation: tone generator requests continuously around a CPU read.
        step(0, 0, 1, 3'd1, 5'd3, 8'h00, 1, 3'd0, 5'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 3'd0, 5'd0, 8'h00, 1, 3'(i % 5), 5'(i + 2));
            ack_seen[i] = obs_ack;
        end
        check("starve_ack_t1", ack_seen[0], 1);
        check("starve_ack_t2", ack_seen[1], 1);
        check("starve_ack_t3", ack_seen[2], 1);
        check("starve_ack_t4", ack_seen[3], 0);
        check("starve_ack_t5", ack_seen[4], 1);
        idle(6);

        // Latest write wins while the tone generator blocks the first one.
        we_count = 0;
        step(0, 1, 0, 3'd3, 5'd7, 8'h11, 1, 3'd4, 5'd0);
        we_count += obs_we;
        step(0, 1, 0, 3'd3, 5'd7, 8'h22, 1, 3'd4, 5'd1);
        we_count += obs_we;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 3'd0, 5'd0, 8'h00, 1, 3'd4, 5'(i + 2));
            we_count += obs_we;
        end
        for (int i = 0; i < 6; i++) begin
            idle(1);
            we_count += obs_we;
        end
        check("overwrite_we_count", we_count, 1);

        // Invalid ids: read returns FF with no RAM cycle, write vanishes.
        step(0, 0, 1, 3'd6, 5'd9, 8'h00, 0, 3'd0, 5'd0);
        idle(5);
        step(0, 1, 0, 3'd7, 5'd2, 8'h33, 0, 3'd0, 5'd0);
        idle(3);
        step(0, 0, 0, 3'd0, 5'd0, 8'h00, 1, 3'd6, 5'd4);
        idle(4);

        // Reset in the cycle after ram_re of a CPU read: no return follows.
        step(0, 0, 1, 3'd0, 5'd8, 8'h00, 0, 3'd0, 5'd0);
        idle(2);
        step(1, 0, 0, 3'd0, 5'd0, 8'h00, 0, 3'd0, 5'd0);
        step(1, 0, 0, 3'd0, 5'd0, 8'h00, 0, 3'd0, 5'd0);
        idle(6);

        // Random traffic.
        tg_hold = 0; tg_hid = '0; tg_ha = '0;
        for (int i = 0; i < 2000; i++) begin
            bit rst, we, oe;
            rst = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 5) == 0);
            oe  = ($urandom_range(0, 4) == 0);
            if (!tg_hold && $urandom_range(0, 2) == 0) begin
                tg_hold = 1;
                tg_hid  = 3'($urandom_range(0, 7));
                tg_ha   = 5'($urandom);
            end
            if (rst) begin
                tg_hold = 0;
                step(1, 0, 0, 3'd0, 5'd0, 8'h00, 0, 3'd0, 5'd0);
            end else begin
                step(0, we, oe, 3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom),
                     tg_hold, tg_hid, tg_ha);
                if (m_tg_won) tg_hold = 0;
            end
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
